keypad_scan: RTL
================

KEYPAD_SCAN -- requirements
Module: keypad_scan

Interface
REQ-001 SCAN_DIV, default 50000, clocks each column stays driven during scan (minimum 4).
REQ-002 DEBOUNCE_CNT, default 500000, consecutive stable clocks needed to accept a press or a release (minimum 2).
REQ-003 REPEAT_DELAY, default 25000000, clocks from accepted press to first repeat (used only with KEYPAD_REPEAT_EN).
REQ-004 REPEAT_RATE, default 5000000, clocks between later repeats (used only with KEYPAD_REPEAT_EN).
REQ-005 clk  input  1  single system clock; all logic on posedge clk.
REQ-006 rst  input  1  reset, synchronous and active-high.
REQ-007 row  input  4  keypad rows, asynchronous, active-low, externally pulled up.
REQ-008 col  output 4  column drive, active-low, exactly one bit low at all times.
REQ-009 key  output 4  code of last accepted key, key = 4*row_index + col_index.
REQ-010 key_valid  output 1  one-cycle pulse for each accepted press (and each repeat).
REQ-011 key_held  output 1  high from accepted press until accepted release.

Function
REQ-012 The row input SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value rs.
REQ-013 The FSM SHALL have four states: SCAN, DEBOUNCE, PRESSED, RELEASE.
REQ-014 In SCAN, col SHALL step through 1110, 1101, 1011, 0111 and wrap, advancing every SCAN_DIV clocks.
REQ-015 On the last dwell cycle of a column in SCAN, if rs != 1111, the block SHALL latch the candidate key and go to DEBOUNCE with col frozen.
REQ-016 If several rows are low, the lowest-index low row SHALL win.
REQ-017 In DEBOUNCE, each clock with the same rs SHALL increment the counter; after DEBOUNCE_CNT such clocks the block SHALL go to PRESSED.
REQ-018 In DEBOUNCE, any change of rs (including release) SHALL return the block to SCAN with the counter cleared, scanning resumed at the next column.
REQ-019 On entry to PRESSED, key SHALL update and key_valid SHALL pulse in the same cycle; key_held SHALL rise in that cycle.
REQ-020 In PRESSED, rs == 1111 SHALL move the block to RELEASE; col stays frozen.
REQ-021 In RELEASE, DEBOUNCE_CNT consecutive clocks of rs == 1111 SHALL return the block to SCAN at the next column with key_held low.
REQ-022 In RELEASE, any low row SHALL restart the release count; no new key_valid SHALL be issued.
REQ-023 key SHALL hold its value until the next accepted press.
REQ-024 Counters SHALL be sized to fit the largest parameter, with no wrap inside a dwell or debounce window.

Reset
REQ-025 rst SHALL set: state=SCAN, col=1110, key=0, key_valid=0, key_held=0, all counters=0, synchronizer=1111.
REQ-026 rst asserted mid-debounce or mid-press SHALL abort the operation with no key_valid pulse.

Configuration
REQ-027 With KEYPAD_REPEAT_EN defined:
  - In PRESSED, key_valid SHALL pulse REPEAT_DELAY clocks after the press pulse, then every REPEAT_RATE clocks while the key stays held.
  - key SHALL be unchanged by repeats.
  - The repeat counter SHALL clear on leaving PRESSED.
REQ-028 Without KEYPAD_REPEAT_EN, the block SHALL give exactly one key_valid per accepted press, and the REPEAT_* parameters SHALL have no effect.

Structure
REQ-029 Package keypad_pkg SHALL hold the state encoding, the col pattern constants, and the row-to-index priority function.
REQ-030 Sub-module keypad_sync (2-flop, 4-bit, reset value 1111) SHALL implement the synchronizer.

Verification
All scenarios use SCAN_DIV=4, DEBOUNCE_CNT=8, REPEAT_DELAY=32, REPEAT_RATE=16.
REQ-031 Reset: after rst, col=1110, key=0, key_valid=0, key_held=0; col reaches 1101 after 4 clocks and wraps to 1110 after 16.
REQ-032 Press row 2 while col=1011, held stable: expect one key_valid with key=0xA (4*2+2) about 10 clocks after the dwell end, then key_held=1.
REQ-033 Bounce: row 0 low for 5 clocks then high during col 0 dwell: expect no key_valid, return to SCAN, col advances to 1101.
REQ-034 Release: after REQ-032, release with 3-clock glitches: expect key_held to stay 1 until 8 clean high clocks, then 0, with no second key_valid.
REQ-035 Simultaneous press of rows 1 and 3 on col 1: expect key=0x5; rst asserted during DEBOUNCE gives no pulse and reset values.
REQ-036 KEYPAD_REPEAT_EN: hold key 0xF: expect pulses at press, +32, +48, +64 clocks; without the macro, exactly one pulse.

Source files
------------

// File: rtl/keypad_pkg.sv
// keypad_pkg: state encoding, column drive patterns and row priority for keypad_scan
package keypad_pkg;
  typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, RELEASE} state_t;
  localparam logic [3:0][3:0] COL_PAT = {4'b0111, 4'b1011, 4'b1101, 4'b1110};
  function automatic logic [1:0] row_index(input logic [3:0] rs);
    row_index = 2'd0;
    for (int i = 3; i >= 0; i--) if (!rs[i]) row_index = 2'(i);
  endfunction
  function automatic int unsigned umax(input int unsigned a, input int unsigned b);
    umax = a > b ? a : b;
  endfunction
endpackage

// File: rtl/keypad_sync.sv
// keypad_sync: 2-flop synchronizer for the active-low row inputs, resets to released
module keypad_sync (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] d,
  output logic [3:0] q
);
  logic [3:0] s1;
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 4'hF;
      q  <= 4'hF;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end
endmodule

// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 keypad column scanner with press/release debounce.
// Define KEYPAD_REPEAT_EN to enable auto-repeat of key_valid while a key is held.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned DEBOUNCE_CNT = 500000,
  parameter int unsigned REPEAT_DELAY = 25000000,
  parameter int unsigned REPEAT_RATE  = 5000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key,
  output logic       key_valid,
  output logic       key_held
);
  localparam int unsigned MAXP = umax(umax(SCAN_DIV, DEBOUNCE_CNT), umax(REPEAT_DELAY, REPEAT_RATE));
  localparam int CW = $clog2(MAXP + 1);
  logic [3:0] rs, cand_rs, cand_key;
  logic [1:0] col_idx;
  logic [CW-1:0] div, cnt;
  state_t state, next;
  logic idle, dwell_end, deb_done, press, adv, rep_fire;
  keypad_sync u_sync (.clk(clk), .rst(rst), .d(row), .q(rs));
  always_comb begin
    idle      = rs == 4'hF;
    dwell_end = div == CW'(SCAN_DIV - 1);
    deb_done  = cnt == CW'(DEBOUNCE_CNT - 1);
  end
  always_ff @(posedge clk) state <= rst ? SCAN : next;
  always_comb begin
    next = state;
    case (state)
      SCAN:     next = dwell_end && !idle ? DEBOUNCE : SCAN;
      DEBOUNCE: next = rs != cand_rs ? SCAN : deb_done ? PRESSED : DEBOUNCE;
      PRESSED:  next = idle ? RELEASE : PRESSED;
      RELEASE:  next = idle && deb_done ? SCAN : RELEASE;
      default:  next = SCAN;
    endcase
  end
  always_comb begin
    col      = COL_PAT[col_idx];
    key_held = state == PRESSED || state == RELEASE;
    press    = state == DEBOUNCE && next == PRESSED;
    adv      = next == SCAN && (state != SCAN || dwell_end);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      col_idx   <= '0;
      div       <= '0;
      cnt       <= '0;
      cand_rs   <= 4'hF;
      cand_key  <= '0;
      key       <= '0;
      key_valid <= 1'b0;
    end else begin
      col_idx   <= adv ? col_idx + 2'd1 : col_idx;
      div       <= state == SCAN && !dwell_end ? div + CW'(1) : '0;
      cnt       <= state == next && (state == DEBOUNCE || (state == RELEASE && idle)) ? cnt + CW'(1) : '0;
      key_valid <= press || rep_fire;
      key       <= press ? cand_key : key;
      if (state == SCAN && dwell_end) begin
        cand_rs  <= rs;
        cand_key <= {row_index(rs), col_idx};
      end
    end
  end
`ifdef KEYPAD_REPEAT_EN
  logic [CW-1:0] rep;
  logic rep_done;
  always_comb rep_fire = state == PRESSED && next == PRESSED &&
                         rep == (rep_done ? CW'(REPEAT_RATE - 1) : CW'(REPEAT_DELAY - 1));
  always_ff @(posedge clk) begin
    if (rst) begin
      rep      <= '0;
      rep_done <= 1'b0;
    end else begin
      rep      <= state == PRESSED && !rep_fire ? rep + CW'(1) : '0;
      rep_done <= state == PRESSED && (rep_done || rep_fire);
    end
  end
`else
  always_comb rep_fire = 1'b0;
`endif
endmodule
